// File: rtl/uart_rx_param_pkg.sv
// uart_rx_param_pkg
//   Shared definitions for the parametrised UART receiver (and the matching
//   transmitter that will reuse them):
//     - rx_state_t      : 3-bit receiver FSM state encoding
//     - PARITY_MODE_*   : parity-mode constants (even / odd)
//     - parity_mismatch : parity check on a reduced data word plus parity bit
package uart_rx_param_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam logic PARITY_MODE_EVEN = 1'b0;
  localparam logic PARITY_MODE_ODD  = 1'b1;

  // data_xor is the XOR-reduction of the received data bits. A clean even
  // frame has data_xor ^ parity_bit == 0, a clean odd frame has it == 1.
  function automatic logic parity_mismatch(input logic data_xor,
                                           input logic parity_bit,
                                           input logic odd_mode);
    return (data_xor ^ parity_bit) ^ (odd_mode == PARITY_MODE_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
//   Brings the asynchronous serial line into the i_clk domain and produces a
//   registered one-cycle pulse on each high-to-low transition.
// Ports
//   i_clk        in   system clock
//   i_rst        in   asynchronous active-high reset
//   i_rx_serial  in   raw serial line, idle high
//   o_rx_line    out  synchronised line level
//   o_rx_fall    out  1-cycle pulse, high in the first cycle o_rx_line is low
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rx_serial,
  output logic o_rx_line,
  output logic o_rx_fall
);

  logic sync_p0;
  logic sync_p1;
  logic vld_p0;
  logic vld_p1;

  // The sync flops reset to 1 (idle level). That alone would make a line
  // already low at reset release look like a 1->0 edge as the reset value
  // drains out, so the valid pipeline keeps the edge detector disarmed until
  // sync_p1 holds a genuinely sampled value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_p0   <= 1'b1;
      sync_p1   <= 1'b1;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      o_rx_fall <= 1'b0;
    end else begin
      // stage p0: metastability capture
      sync_p0   <= i_rx_serial;
      vld_p0    <= 1'b1;
      // stage p1: settled line level; edge pulse aligned with it
      sync_p1   <= sync_p0;
      vld_p1    <= vld_p0;
      o_rx_fall <= vld_p1 & sync_p1 & ~sync_p0;
    end
  end

  assign o_rx_line = sync_p1;

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param
//   Parametrised UART receiver: configurable data width, bit period, optional
//   parity and one or two stop bits. Samples each bit at its midpoint,
//   rejects start-bit glitches and flags framing / parity errors. Delivers one
//   word per frame with a single-cycle strobe.
// Parameters
//   DATA_WIDTH    data bits per frame, LSB first (1..32)
//   CLKS_PER_BIT  i_clk cycles per bit (>= 4)
//   PARITY_EN     1 = parity bit follows the data bits
//   PARITY_ODD    0 = even, 1 = odd parity (ignored when PARITY_EN = 0)
//   STOP_BITS     1 or 2
// Ports
//   i_clk         in   system clock
//   i_rst         in   asynchronous active-high reset
//   i_rx_serial   in   serial line, idle high
//   o_rx_done     out  1-cycle strobe; data and error flags valid
//   o_rx_data     out  last received word, held until the next strobe
//   o_frame_err   out  a stop bit sampled 0; held until the next strobe
//   o_parity_err  out  parity mismatch; held until the next strobe
//   o_busy        out  frame in progress
module uart_rx_param
  import uart_rx_param_pkg::*;
#(
  parameter int DATA_WIDTH   = 24,
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx_serial,
  output logic                  o_rx_done,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_frame_err,
  output logic                  o_parity_err,
  output logic                  o_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic             ODD_MODE  = (PARITY_ODD != 0) ? PARITY_MODE_ODD
                                                             : PARITY_MODE_EVEN;

  logic                  rx_line;
  logic                  rx_fall;

  rx_state_t             state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic                  frame_err_acc;
  logic                  parity_err_acc;
  logic [DATA_WIDTH-1:0] shift_reg;

  logic                  half_end;
  logic                  bit_end;
  logic                  shift_en;

  uart_rx_sync u_sync (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rx_serial (i_rx_serial),
    .o_rx_line   (rx_line),
    .o_rx_fall   (rx_fall)
  );

  assign half_end = (bit_cnt == HALF_LAST);
  assign bit_end  = (bit_cnt == BIT_LAST);
  assign shift_en = (state == ST_DATA) && bit_end;

  // Control FSM with registered outputs. The start bit is checked at its
  // midpoint; every later bit is sampled a full bit period after the
  // previous sample, so all samples land mid-bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= ST_IDLE;
      bit_cnt        <= '0;
      bit_idx        <= '0;
      frame_err_acc  <= 1'b0;
      parity_err_acc <= 1'b0;
      o_rx_done      <= 1'b0;
      o_rx_data      <= '0;
      o_frame_err    <= 1'b0;
      o_parity_err   <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      o_rx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          bit_cnt        <= '0;
          bit_idx        <= '0;
          frame_err_acc  <= 1'b0;
          parity_err_acc <= 1'b0;
          if (rx_fall) begin
            state  <= ST_START;
            o_busy <= 1'b1;
          end
        end

        ST_START: begin
          if (half_end) begin
            bit_cnt <= '0;
            if (rx_line) begin
              // line back high at mid-start: a glitch, not a frame
              state  <= ST_IDLE;
              o_busy <= 1'b0;
            end else begin
              state <= ST_DATA;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              state   <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        ST_PARITY: begin
          if (bit_end) begin
            bit_cnt        <= '0;
            parity_err_acc <= parity_mismatch(^shift_reg, rx_line, ODD_MODE);
            state          <= ST_STOP;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        ST_STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == STOP_LAST) begin
              // Last stop sample: publish the frame and re-arm immediately,
              // half a bit before a back-to-back start bit can begin.
              state        <= ST_IDLE;
              bit_idx      <= '0;
              o_busy       <= 1'b0;
              o_rx_done    <= 1'b1;
              o_rx_data    <= shift_reg;
              o_frame_err  <= frame_err_acc | ~rx_line;
              o_parity_err <= parity_err_acc;
            end else begin
              // every stop bit is sampled even after an early 0
              frame_err_acc <= frame_err_acc | ~rx_line;
              bit_idx       <= bit_idx + IDX_W'(1);
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: assembly register, kept apart from o_rx_data so the output
  // never shows a partial word. Bits enter at the top and move down, leaving
  // the first-received bit in position 0 after DATA_WIDTH shifts.
  generate
    if (DATA_WIDTH == 1) begin : g_shift_1
      always_ff @(posedge i_clk) begin
        if (shift_en) shift_reg <= rx_line;
      end
    end else begin : g_shift_n
      always_ff @(posedge i_clk) begin
        if (shift_en) shift_reg <= {rx_line, shift_reg[DATA_WIDTH-1:1]};
      end
    end
  endgenerate

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

  localparam int CPB  = 16;
  localparam int DW   = 24;
  localparam int NDUT = 3;   // 0: no parity/1 stop, 1: even parity/1 stop, 2: no parity/2 stop

  typedef struct {
    int          d;
    logic [23:0] data;
    logic        fe;
    logic        pe;
    int          cyc;
  } rec_t;

  typedef struct {
    int          d;
    logic [23:0] data;
    logic        par;
    logic [1:0]  stops;
    logic [23:0] exp_data;
    logic        exp_fe;
    logic        exp_pe;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_w   [NDUT];
  logic          done_w [NDUT];
  logic [DW-1:0] data_w [NDUT];
  logic          fe_w   [NDUT];
  logic          pe_w   [NDUT];
  logic          busy_w [NDUT];

  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          done_cnt  [NDUT];
  int          busy_cyc  [NDUT];
  logic [23:0] last_data [NDUT];
  logic        last_fe   [NDUT];
  logic        last_pe   [NDUT];
  int          last_cyc  [NDUT];
  rec_t        hist[$];

  uart_rx_param #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_rx_serial(rx_w[0]), .o_rx_done(done_w[0]), .o_rx_data(data_w[0]),
    .o_frame_err(fe_w[0]), .o_parity_err(pe_w[0]), .o_busy(busy_w[0]));

  uart_rx_param #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_p (
    .i_clk(clk), .i_rst(rst), .i_rx_serial(rx_w[1]), .o_rx_done(done_w[1]), .o_rx_data(data_w[1]),
    .o_frame_err(fe_w[1]), .o_parity_err(pe_w[1]), .o_busy(busy_w[1]));

  uart_rx_param #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_rx_serial(rx_w[2]), .o_rx_done(done_w[2]), .o_rx_data(data_w[2]),
    .o_frame_err(fe_w[2]), .o_parity_err(pe_w[2]), .o_busy(busy_w[2]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (busy_w[d] === 1'b1) busy_cyc[d] = busy_cyc[d] + 1;
      if (done_w[d] === 1'b1) begin
        done_cnt[d]  = done_cnt[d] + 1;
        last_data[d] = data_w[d];
        last_fe[d]   = fe_w[d];
        last_pe[d]   = pe_w[d];
        last_cyc[d]  = cyc;
        hist.push_back('{d, data_w[d], fe_w[d], pe_w[d], cyc});
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int d, input logic v);
    rx_w[d] = v;
  endtask

  // Reference: frame length in bits after the start bit, per receiver flavour.
  function automatic int frame_bits(input int d);
    return DW + ((d == 1) ? 1 : 0) + ((d == 2) ? 2 : 1);
  endfunction

  // Expected cycle of the strobe: 2 cycles through the synchroniser, then
  // half a bit + N bits + 1 from the first synchronised low cycle.
  function automatic int exp_done_cyc(input int d, input int t0);
    return t0 + 2 + CPB / 2 + frame_bits(d) * CPB + 1;
  endfunction

  function automatic logic model_pe(input int d, input logic [23:0] data, input logic par);
    return (d == 1) ? (^{data, par}) : 1'b0;
  endfunction

  function automatic logic model_fe(input int d, input logic [1:0] stops);
    return (d == 2) ? !(stops[0] && stops[1]) : !stops[0];
  endfunction

  // Drives one whole frame; leaves the line at the last stop-bit level.
  task automatic send_frame(input int d, input logic [23:0] data, input logic par,
                            input logic [1:0] stops, output int t0);
    t0 = cyc;
    set_rx(d, 1'b0);
    hold(CPB);
    for (int i = 0; i < DW; i++) begin
      set_rx(d, data[i]);
      hold(CPB);
    end
    if (d == 1) begin
      set_rx(d, par);
      hold(CPB);
    end
    set_rx(d, stops[0]);
    hold(CPB);
    if (d == 2) begin
      set_rx(d, stops[1]);
      hold(CPB);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int t0;
    int c0;
    c0 = done_cnt[v.d];
    send_frame(v.d, v.data, v.par, v.stops, t0);
    set_rx(v.d, 1'b1);
    hold(2 * CPB);
    chk("strobe_count", done_cnt[v.d] - c0, 1);
    chk("rx_data", int'(last_data[v.d]), int'(v.exp_data));
    chk("frame_err", int'(last_fe[v.d]), int'(v.exp_fe));
    chk("parity_err", int'(last_pe[v.d]), int'(v.exp_pe));
    chk("latency", last_cyc[v.d], exp_done_cyc(v.d, t0));
  endtask

  task automatic test_glitch();
    int c0;
    int b0;
    c0 = done_cnt[0];
    b0 = busy_cyc[0];
    set_rx(0, 1'b0);
    hold(5);
    set_rx(0, 1'b1);
    hold(3 * CPB);
    chk("glitch_busy_pulsed", int'(busy_cyc[0] > b0), 1);
    chk("glitch_no_strobe", done_cnt[0] - c0, 0);
    chk("glitch_idle_again", int'(busy_w[0]), 0);
  endtask

  task automatic test_break();
    int   t0;
    int   c0;
    vec_t v;
    c0 = done_cnt[0];
    send_frame(0, 24'h0000AA, 1'b0, 2'b00, t0);
    hold(100 * CPB);   // line stays low
    chk("break_one_strobe", done_cnt[0] - c0, 1);
    chk("break_frame_err", int'(last_fe[0]), 1);
    chk("break_data", int'(last_data[0]), 24'h0000AA);
    set_rx(0, 1'b1);
    hold(2 * CPB);
    v = '{0, 24'h000055, 1'b0, 2'b11, 24'h000055, 1'b0, 1'b0};
    run_vec(v);
  endtask

  task automatic test_back_to_back();
    int          t1;
    int          t2;
    int          c0;
    int          h0;
    int          got;
    rec_t        r [2];
    c0  = done_cnt[2];
    h0  = hist.size();
    got = 0;
    send_frame(2, 24'h123456, 1'b0, 2'b11, t1);
    send_frame(2, 24'hFEDCBA, 1'b0, 2'b11, t2);
    set_rx(2, 1'b1);
    hold(2 * CPB);
    chk("b2b_strobes", done_cnt[2] - c0, 2);
    for (int i = h0; i < hist.size(); i++) begin
      if (hist[i].d == 2 && got < 2) begin
        r[got] = hist[i];
        got++;
      end
    end
    if (got == 2) begin
      chk("b2b_data1", int'(r[0].data), 24'h123456);
      chk("b2b_data2", int'(r[1].data), 24'hFEDCBA);
      chk("b2b_flags", int'({r[0].fe, r[0].pe, r[1].fe, r[1].pe}), 0);
      chk("b2b_latency1", r[0].cyc, exp_done_cyc(2, t1));
      chk("b2b_latency2", r[1].cyc, exp_done_cyc(2, t2));
    end else begin
      chk("b2b_records", got, 2);
    end
  endtask

  task automatic test_reset_mid_frame();
    int   c0;
    vec_t v;
    c0 = done_cnt[0];
    set_rx(0, 1'b0);
    hold(CPB);
    for (int i = 0; i < 10; i++) begin
      set_rx(0, 1'b0);
      hold(CPB);
    end
    set_rx(0, 1'b0);   // inside data bit 10
    hold(CPB / 2);
    chk("pre_reset_busy", int'(busy_w[0]), 1);
    rst = 1'b1;
    #1;
    chk("async_reset_data", int'(data_w[0]), 0);
    chk("async_reset_flags", int'({done_w[0], fe_w[0], pe_w[0], busy_w[0]}), 0);
    hold(3);
    rst = 1'b0;
    hold(5);           // line still low after release: must not start a frame
    set_rx(0, 1'b1);
    hold(3 * CPB);
    chk("reset_no_strobe", done_cnt[0] - c0, 0);
    chk("reset_idle", int'(busy_w[0]), 0);
    v = '{0, 24'h00FF00, 1'b0, 2'b11, 24'h00FF00, 1'b0, 1'b0};
    run_vec(v);
  endtask

  initial begin
    vec_t        vt [10];
    vec_t        rv;
    logic [1:0]  st;

    vt[0] = '{0, 24'hA5C30F, 1'b0, 2'b11, 24'hA5C30F, 1'b0, 1'b0};
    vt[1] = '{1, 24'h000001, 1'b0, 2'b11, 24'h000001, 1'b0, 1'b1};
    vt[2] = '{1, 24'h000001, 1'b1, 2'b11, 24'h000001, 1'b0, 1'b0};
    vt[3] = '{1, 24'h000003, 1'b0, 2'b11, 24'h000003, 1'b0, 1'b0};
    vt[4] = '{1, 24'h800000, 1'b0, 2'b10, 24'h800000, 1'b1, 1'b1};
    vt[5] = '{0, 24'hFFFFFF, 1'b0, 2'b11, 24'hFFFFFF, 1'b0, 1'b0};
    vt[6] = '{0, 24'h000000, 1'b0, 2'b11, 24'h000000, 1'b0, 1'b0};
    vt[7] = '{2, 24'h5A5A5A, 1'b0, 2'b01, 24'h5A5A5A, 1'b1, 1'b0};
    vt[8] = '{2, 24'hC3C3C3, 1'b0, 2'b10, 24'hC3C3C3, 1'b1, 1'b0};
    vt[9] = '{2, 24'h00F0F0, 1'b0, 2'b11, 24'h00F0F0, 1'b0, 1'b0};

    rx_w[0] = 1'b0;    // held low through reset release
    rx_w[1] = 1'b1;
    rx_w[2] = 1'b1;

    hold(4);
    for (int d = 0; d < NDUT; d++) begin
      chk("reset_flags", int'({done_w[d], fe_w[d], pe_w[d], busy_w[d]}), 0);
      chk("reset_data", int'(data_w[d]), 0);
    end
    rst = 1'b0;
    hold(20);
    chk("low_at_release_busy", busy_cyc[0], 0);
    chk("low_at_release_strobe", done_cnt[0], 0);
    set_rx(0, 1'b1);
    hold(2 * CPB);

    for (int i = 0; i < 10; i++) run_vec(vt[i]);

    test_glitch();
    test_break();
    test_reset_mid_frame();
    test_back_to_back();

    for (int i = 0; i < 12; i++) begin
      rv.d    = $urandom_range(0, 2);
      rv.data = 24'($urandom);
      rv.par  = 1'($urandom_range(0, 1));
      st      = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      rv.stops    = st;
      rv.exp_data = rv.data;
      rv.exp_fe   = model_fe(rv.d, st);
      rv.exp_pe   = model_pe(rv.d, rv.data, rv.par);
      run_vec(rv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
